// File: rtl/decstage_pipe.sv
// Pipelined decode stage: register file with write bypass, immediate generation,
// store-lane replication and an ID/EX register with valid/ready, load-use stall and flush.
module decstage_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(REG_CNT)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [31:0]       Instr,
    input  logic              Rd2_sel,
    input  logic              Dst_sel,
    input  logic [1:0]        Imm_mode,
    input  logic [1:0]        Byte_mode,
    input  logic              Mem_rd,
    input  logic              Wb_en,
    input  logic [AW-1:0]     Wb_addr,
    input  logic [DATA_W-1:0] Wb_data,
    input  logic              Flush,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Ex_RF_A,
    output logic [DATA_W-1:0] Ex_RF_B,
    output logic [DATA_W-1:0] Ex_Immed,
    output logic [AW-1:0]     Ex_dest,
    output logic              Ex_mem_rd
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ex_rf_a_q, ex_rf_a_d;
    logic [DATA_W-1:0] ex_rf_b_q, ex_rf_b_d;
    logic [DATA_W-1:0] ex_immed_q, ex_immed_d;
    logic [AW-1:0]     ex_dest_q, ex_dest_d;
    logic              ex_mem_rd_q, ex_mem_rd_d;

    logic [AW-1:0]     rs_addr, rt_addr, rd_addr, rd2_addr, dst_addr;
    logic [DATA_W-1:0] rf_a, rf_b, lane_b, dec_immed;
    logic [15:0]       imm16;
    logic              adv, haz, accept;

    logic unused_instr;
    assign unused_instr = ^Instr;

    // Decode: register fields, bypassed reads, immediate and store-lane formatting
    always_comb begin
        rs_addr  = Instr[21 +: AW];
        rt_addr  = Instr[16 +: AW];
        rd_addr  = Instr[11 +: AW];
        rd2_addr = Rd2_sel ? rd_addr : rt_addr;
        dst_addr = Dst_sel ? rt_addr : rd_addr;

        rf_a = regs_q[rs_addr];
        if (Wb_en && Wb_addr == rs_addr) rf_a = Wb_data;
        if (ZERO_REG && rs_addr == '0) rf_a = '0;

        rf_b = regs_q[rd2_addr];
        if (Wb_en && Wb_addr == rd2_addr) rf_b = Wb_data;
        if (ZERO_REG && rd2_addr == '0) rf_b = '0;

        imm16 = Instr[15:0];
        case (Imm_mode)
            2'b00:   dec_immed = DATA_W'(imm16);
            2'b01:   dec_immed = DATA_W'($signed(imm16));
            2'b10:   dec_immed = DATA_W'({imm16, 16'h0000});
            default: dec_immed = DATA_W'($signed(imm16)) << 2;
        endcase

        case (Byte_mode)
            2'b01:   lane_b = {(DATA_W/8){rf_b[7:0]}};
            2'b10:   lane_b = {(DATA_W/16){rf_b[15:0]}};
            default: lane_b = rf_b;
        endcase
    end

    // Handshake and load-use hazard against the instruction held in ID/EX
    always_comb begin
        adv = !out_valid_q || Out_ready;
        haz = In_valid && out_valid_q && ex_mem_rd_q && (ex_dest_q != '0) &&
              ((ex_dest_q == rs_addr) || (ex_dest_q == rd2_addr));
        accept   = adv && In_valid && !haz && !Flush;
        In_ready = Reset_n && adv && !haz && !Flush;
    end

    always_comb begin
        regs_d = regs_q;
        if (Wb_en && !(ZERO_REG && Wb_addr == '0) && (int'(Wb_addr) < REG_CNT))
            regs_d[Wb_addr] = Wb_data;

        out_valid_d = out_valid_q;
        ex_rf_a_d   = ex_rf_a_q;
        ex_rf_b_d   = ex_rf_b_q;
        ex_immed_d  = ex_immed_q;
        ex_dest_d   = ex_dest_q;
        ex_mem_rd_d = ex_mem_rd_q;

        // Flush and bubbles clear only the valid bit; payload holds its last value
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ex_rf_a_d   = rf_a;
            ex_rf_b_d   = lane_b;
            ex_immed_d  = dec_immed;
            ex_dest_d   = dst_addr;
            ex_mem_rd_d = Mem_rd;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
            out_valid_q <= 1'b0;
            ex_rf_a_q   <= '0;
            ex_rf_b_q   <= '0;
            ex_immed_q  <= '0;
            ex_dest_q   <= '0;
            ex_mem_rd_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            ex_rf_a_q   <= ex_rf_a_d;
            ex_rf_b_q   <= ex_rf_b_d;
            ex_immed_q  <= ex_immed_d;
            ex_dest_q   <= ex_dest_d;
            ex_mem_rd_q <= ex_mem_rd_d;
        end
    end

    assign Out_valid = out_valid_q;
    assign Ex_RF_A   = ex_rf_a_q;
    assign Ex_RF_B   = ex_rf_b_q;
    assign Ex_Immed  = ex_immed_q;
    assign Ex_dest   = ex_dest_q;
    assign Ex_mem_rd = ex_mem_rd_q;

endmodule

// File: tb/tb_decstage_pipe.sv
// Bench for decstage_pipe: directed handshake/hazard sequences, an immediate/lane vector
// table (32- and 64-bit instances), then randomized traffic against a behavioural model.
module tb_decstage_pipe;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        In_valid = 1'b0, Rd2_sel = 1'b0, Dst_sel = 1'b0, Mem_rd = 1'b0;
    logic        Wb_en = 1'b0, Flush = 1'b0, Out_ready = 1'b1;
    logic [31:0] Instr = '0;
    logic [1:0]  Imm_mode = '0, Byte_mode = '0;
    logic [4:0]  Wb_addr = '0;
    logic [31:0] Wb_data = '0;

    logic        In_ready, Out_valid, Ex_mem_rd;
    logic [31:0] Ex_RF_A, Ex_RF_B, Ex_Immed;
    logic [4:0]  Ex_dest;

    logic        w_In_ready, w_Out_valid, w_Ex_mem_rd;
    logic [63:0] w_Ex_RF_A, w_Ex_RF_B, w_Ex_Immed;
    logic [3:0]  w_Ex_dest;
    logic [3:0]  w_Wb_addr;
    logic [63:0] w_Wb_data;
    assign w_Wb_addr = Wb_addr[3:0];
    assign w_Wb_data = {32'h0, Wb_data};

    always #5 Clk = ~Clk;

    decstage_pipe #(.DATA_W(32), .REG_CNT(32), .ZERO_REG(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
        .Instr(Instr), .Rd2_sel(Rd2_sel), .Dst_sel(Dst_sel), .Imm_mode(Imm_mode),
        .Byte_mode(Byte_mode), .Mem_rd(Mem_rd), .Wb_en(Wb_en), .Wb_addr(Wb_addr),
        .Wb_data(Wb_data), .Flush(Flush), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Ex_RF_A(Ex_RF_A), .Ex_RF_B(Ex_RF_B), .Ex_Immed(Ex_Immed), .Ex_dest(Ex_dest),
        .Ex_mem_rd(Ex_mem_rd)
    );

    decstage_pipe #(.DATA_W(64), .REG_CNT(16), .ZERO_REG(1'b1)) dut_w (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(w_In_ready),
        .Instr(Instr), .Rd2_sel(Rd2_sel), .Dst_sel(Dst_sel), .Imm_mode(Imm_mode),
        .Byte_mode(Byte_mode), .Mem_rd(Mem_rd), .Wb_en(Wb_en), .Wb_addr(w_Wb_addr),
        .Wb_data(w_Wb_data), .Flush(Flush), .Out_valid(w_Out_valid), .Out_ready(Out_ready),
        .Ex_RF_A(w_Ex_RF_A), .Ex_RF_B(w_Ex_RF_B), .Ex_Immed(w_Ex_Immed), .Ex_dest(w_Ex_dest),
        .Ex_mem_rd(w_Ex_mem_rd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {6'h0, rs, rt, imm};
    endfunction

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  imode;
        logic [1:0]  bmode;
        logic [31:0] e_imm;
        logic [31:0] e_b;
        logic [63:0] e_imm64;
        logic [63:0] e_b64;
    } vec_t;
    vec_t tbl [8];

    // Behavioural reference: architectural register file plus one ID/EX slot
    logic [31:0] m_rf [32];
    logic        m_valid, m_memrd;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_dest;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (Wb_en && Wb_addr == a) return Wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [15:0] i, input logic [1:0] m);
        int s;
        s = int'($signed(i));
        case (m)
            2'd0:    return {16'h0, i};
            2'd1:    return 32'(s);
            2'd2:    return 32'(i) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    function automatic logic [31:0] m_lane(input logic [31:0] b, input logic [1:0] m);
        case (m)
            2'd1:    return 32'(b[7:0]) * 32'h0101_0101;
            2'd2:    return 32'(b[15:0]) * 32'h0001_0001;
            default: return b;
        endcase
    endfunction

    initial begin
        tbl[0] = '{16'h8004, 2'd0, 2'd0, 32'h0000_8004, 32'h1122_3344,
                   64'h0000_0000_0000_8004, 64'h0000_0000_1122_3344};
        tbl[1] = '{16'h8004, 2'd1, 2'd1, 32'hFFFF_8004, 32'h4444_4444,
                   64'hFFFF_FFFF_FFFF_8004, 64'h4444_4444_4444_4444};
        tbl[2] = '{16'h8004, 2'd2, 2'd2, 32'h8004_0000, 32'h3344_3344,
                   64'h0000_0000_8004_0000, 64'h3344_3344_3344_3344};
        tbl[3] = '{16'h8004, 2'd3, 2'd3, 32'hFFFE_0010, 32'h1122_3344,
                   64'hFFFF_FFFF_FFFE_0010, 64'h0000_0000_1122_3344};
        tbl[4] = '{16'h1234, 2'd0, 2'd1, 32'h0000_1234, 32'h4444_4444,
                   64'h0000_0000_0000_1234, 64'h4444_4444_4444_4444};
        tbl[5] = '{16'h1234, 2'd1, 2'd2, 32'h0000_1234, 32'h3344_3344,
                   64'h0000_0000_0000_1234, 64'h3344_3344_3344_3344};
        tbl[6] = '{16'h1234, 2'd2, 2'd0, 32'h1234_0000, 32'h1122_3344,
                   64'h0000_0000_1234_0000, 64'h0000_0000_1122_3344};
        tbl[7] = '{16'h1234, 2'd3, 2'd3, 32'h0000_48D0, 32'h1122_3344,
                   64'h0000_0000_0000_48D0, 64'h0000_0000_1122_3344};

        // Reset: outputs cleared and no acceptance while held
        In_valid = 1'b1;
        Instr    = mk(5'd1, 5'd2, 16'h0);
        repeat (2) step();
        chk("reset_in_ready", 64'(In_ready), 64'd0);
        chk("reset_out_valid", 64'(Out_valid), 64'd0);
        chk("reset_ex_a", 64'(Ex_RF_A), 64'd0);
        chk("reset_ex_imm", 64'(Ex_Immed), 64'd0);
        In_valid = 1'b0;
        Reset_n  = 1'b1;
        step();

        // Write then read back through ID/EX
        Wb_en = 1'b1; Wb_addr = 5'd5; Wb_data = 32'h1234_5678;
        step();
        Wb_en = 1'b0;
        Instr = mk(5'd5, 5'd0, 16'h0); In_valid = 1'b1;
        #1 chk("accept_ready", 64'(In_ready), 64'd1);
        step();
        chk("rd_out_valid", 64'(Out_valid), 64'd1);
        chk("rd_ex_a", 64'(Ex_RF_A), 64'h1234_5678);

        // Same-cycle bypass, then register-zero behaviour
        Instr = mk(5'd7, 5'd0, 16'h0);
        Wb_en = 1'b1; Wb_addr = 5'd7; Wb_data = 32'hA5A5_0001;
        step();
        chk("bypass_ex_a", 64'(Ex_RF_A), 64'hA5A5_0001);
        Instr = mk(5'd0, 5'd0, 16'h0);
        Wb_addr = 5'd0; Wb_data = 32'h0000_FFFF;
        step();
        chk("r0_bypass", 64'(Ex_RF_A), 64'd0);
        Wb_en = 1'b0;
        step();
        chk("r0_read", 64'(Ex_RF_A), 64'd0);
        Instr = mk(5'd7, 5'd0, 16'h0);
        step();
        chk("r7_stored", 64'(Ex_RF_A), 64'hA5A5_0001);

        // Load-use on rs: one stall cycle, one bubble, then accept
        Instr = mk(5'd1, 5'd2, {5'd3, 11'd0}); Dst_sel = 1'b0; Mem_rd = 1'b1;
        Wb_en = 1'b1; Wb_addr = 5'd3; Wb_data = 32'hCAFE_0003;
        step();
        Wb_en = 1'b0;
        chk("load_dest", 64'(Ex_dest), 64'd3);
        chk("load_memrd", 64'(Ex_mem_rd), 64'd1);
        Instr = mk(5'd3, 5'd0, 16'h0); Mem_rd = 1'b0;
        #1 chk("luse_stall", 64'(In_ready), 64'd0);
        step();
        chk("luse_bubble", 64'(Out_valid), 64'd0);
        #1 chk("luse_release", 64'(In_ready), 64'd1);
        step();
        chk("luse_accept_valid", 64'(Out_valid), 64'd1);
        chk("luse_accept_a", 64'(Ex_RF_A), 64'hCAFE_0003);
        // Load to r3 followed by an unrelated source
        Instr = mk(5'd1, 5'd2, {5'd3, 11'd0}); Mem_rd = 1'b1;
        step();
        Instr = mk(5'd4, 5'd0, 16'h0); Mem_rd = 1'b0;
        #1 chk("no_stall_ready", 64'(In_ready), 64'd1);
        step();
        chk("no_stall_valid", 64'(Out_valid), 64'd1);
        chk("no_stall_memrd", 64'(Ex_mem_rd), 64'd0);
        // Load to r3 followed by r3 on the second read port
        Instr = mk(5'd1, 5'd2, {5'd3, 11'd0}); Mem_rd = 1'b1;
        step();
        Instr = mk(5'd4, 5'd3, 16'h0); Mem_rd = 1'b0;
        #1 chk("rd2_stall", 64'(In_ready), 64'd0);
        step();
        step();

        // Back-pressure holds the payload; flush during the stall drops valid
        Instr = mk(5'd5, 5'd0, 16'h0);
        step();
        Out_ready = 1'b0;
        Instr = mk(5'd7, 5'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 64'(In_ready), 64'd0);
            step();
            chk("bp_valid", 64'(Out_valid), 64'd1);
            chk("bp_ex_a", 64'(Ex_RF_A), 64'h1234_5678);
        end
        Flush = 1'b1;
        #1 chk("flush_in_ready", 64'(In_ready), 64'd0);
        step();
        chk("flush_valid", 64'(Out_valid), 64'd0);
        chk("flush_data_hold", 64'(Ex_RF_A), 64'h1234_5678);
        Flush = 1'b0; Out_ready = 1'b1; In_valid = 1'b0;

        // Immediate and lane table on both widths, r9 = 0x11223344
        Wb_en = 1'b1; Wb_addr = 5'd9; Wb_data = 32'h1122_3344;
        step();
        Wb_en = 1'b0; In_valid = 1'b1; Rd2_sel = 1'b0; Dst_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Instr = mk(5'd9, 5'd9, tbl[i].imm);
            Imm_mode = tbl[i].imode; Byte_mode = tbl[i].bmode;
            step();
            chk("tbl_valid", 64'(Out_valid), 64'd1);
            chk("tbl_imm", 64'(Ex_Immed), 64'(tbl[i].e_imm));
            chk("tbl_b", 64'(Ex_RF_B), 64'(tbl[i].e_b));
            chk("tbl_dest", 64'(Ex_dest), 64'd9);
            chk("tbl64_valid", 64'(w_Out_valid), 64'd1);
            chk("tbl64_imm", w_Ex_Immed, tbl[i].e_imm64);
            chk("tbl64_b", w_Ex_RF_B, tbl[i].e_b64);
            chk("tbl64_a", w_Ex_RF_A, 64'h0000_0000_1122_3344);
        end
        Byte_mode = 2'd0; Imm_mode = 2'd0;

        // Asynchronous reset mid-operation discards ID/EX and register contents
        Instr = mk(5'd5, 5'd0, 16'h0);
        step();
        Reset_n = 1'b0;
        #1 chk("async_rst_valid", 64'(Out_valid), 64'd0);
        chk("async_rst_a", 64'(Ex_RF_A), 64'd0);
        step();
        Reset_n = 1'b1;
        step();
        chk("post_rst_rf", 64'(Ex_RF_A), 64'd0);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        In_valid = 1'b0;
        step();

        // Randomized traffic against the reference model
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        m_valid = 1'b0; m_memrd = 1'b0; m_a = '0; m_b = '0; m_imm = '0; m_dest = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [4:0] rs, rd2, dst;
            logic       adv, haz;
            Instr     = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 11'($urandom)};
            Rd2_sel   = 1'($urandom);
            Dst_sel   = 1'($urandom);
            Imm_mode  = 2'($urandom);
            Byte_mode = 2'($urandom);
            Mem_rd    = 1'($urandom);
            Wb_en     = 1'($urandom);
            Wb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            Wb_data   = $urandom;
            Flush     = ($urandom_range(0, 15) == 0);
            Out_ready = ($urandom_range(0, 3) != 0);
            In_valid  = ($urandom_range(0, 3) != 0);
            #1;
            rs  = Instr[25:21];
            rd2 = Rd2_sel ? Instr[15:11] : Instr[20:16];
            dst = Dst_sel ? Instr[20:16] : Instr[15:11];
            adv = !m_valid || Out_ready;
            haz = In_valid && m_valid && m_memrd && m_dest != 0 && (m_dest == rs || m_dest == rd2);
            chk("rnd_in_ready", 64'(In_ready), 64'(adv && !haz && !Flush));
            if (Flush) begin
                m_valid = 1'b0;
            end else if (adv && In_valid && !haz) begin
                m_valid = 1'b1;
                m_a     = m_read(rs);
                m_b     = m_lane(m_read(rd2), Byte_mode);
                m_imm   = m_ext(Instr[15:0], Imm_mode);
                m_dest  = dst;
                m_memrd = Mem_rd;
            end else if (adv) begin
                m_valid = 1'b0;
            end
            if (Wb_en && Wb_addr != 0) m_rf[Wb_addr] = Wb_data;
            @(posedge Clk);
            #2;
            chk("rnd_valid", 64'(Out_valid), 64'(m_valid));
            chk("rnd_a", 64'(Ex_RF_A), 64'(m_a));
            chk("rnd_b", 64'(Ex_RF_B), 64'(m_b));
            chk("rnd_imm", 64'(Ex_Immed), 64'(m_imm));
            chk("rnd_dest", 64'(Ex_dest), 64'(m_dest));
            chk("rnd_memrd", 64'(Ex_mem_rd), 64'(m_memrd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
